// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory and queues
// {pc, instr} pairs for decode behind a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               halted_q, halted_d;

  logic [31:0]        fifo_pc_q    [DEPTH];
  logic [31:0]        fifo_instr_q [DEPTH];

  logic               pop_c;
  logic               push_c;
  logic               is_halt_c;

  assign pop_c     = (count_q != '0) & id_ready;
  assign push_c    = (state_q == ST_RUN) & fetch_en & ~redirect_valid &
                     ((count_q < CNT_W'(DEPTH)) | pop_c);
  assign is_halt_c = (imem_instr == HALT_WORD);

  // Next-state: redirect overrides any push/pop in the same cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;

    if (redirect_valid) begin
      state_d  = ST_RUN;
      pc_d     = redirect_pc & ~32'd3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (state_q == ST_WAIT) begin
        state_d = ST_RUN;
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (is_halt_c) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_addr = {2'b00, pc_q[31:2]};
  assign id_valid  = (count_q != '0);
  assign id_instr  = id_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
  assign id_pc     = id_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;
  assign halted    = halted_q;

endmodule
